// File: rtl/merger_stream_controller_if.sv
// Handshake bundle shared by the merge controller, its upstream lanes, the merger and the downstream sink.
// The controller connects through the slave modport; the environment side uses master.
interface merger_stream_controller_if #(
    parameter int unsigned RADIX      = 2,
    parameter int unsigned COORD_BITS = 16
);
    logic [RADIX-1:0]            lane_valid;
    logic [RADIX*COORD_BITS-1:0] lane_coord;
    logic [RADIX-1:0]            lane_last;
    logic [RADIX-1:0]            lane_ready;
    logic [RADIX*COORD_BITS-1:0] merger_coord_in;
    logic                        merger_selected;
    logic [RADIX-1:0]            merger_fetch_next;
    logic [COORD_BITS-1:0]       merger_coord;
    logic                        out_valid;
    logic [COORD_BITS-1:0]       out_coord;
    logic                        out_last;
    logic                        out_ready;

    modport master (
        output lane_valid, lane_coord, lane_last, merger_fetch_next, merger_coord, out_ready,
        input  lane_ready, merger_coord_in, merger_selected, out_valid, out_coord, out_last
    );

    modport slave (
        input  lane_valid, lane_coord, lane_last, merger_fetch_next, merger_coord, out_ready,
        output lane_ready, merger_coord_in, merger_selected, out_valid, out_coord, out_last
    );
endinterface

// File: rtl/merger_stream_controller.sv
// Sequences one merger through a merge job: holds one head per lane, drives the merger,
// pops the winning lane, tracks exhausted lanes and marks the end of the merged stream.
module merger_stream_controller #(
    parameter int unsigned RADIX      = 2,
    parameter int unsigned COORD_BITS = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    merger_stream_controller_if.slave    bus,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam logic [COORD_BITS-1:0] SENTINEL = '1;
    localparam logic [RADIX-1:0]      ALL_LANES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_MERGE,
        S_DONE
    } state_t;

    state_t                             state_q, state_d;
    logic [RADIX-1:0][COORD_BITS-1:0]   head_coord_q, head_coord_d;
    logic [RADIX-1:0]                   head_vld_q, head_vld_d;
    logic [RADIX-1:0]                   head_last_q, head_last_d;
    logic [RADIX-1:0]                   exhausted_q, exhausted_d;
    logic                               error_q, error_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;

    logic [RADIX-1:0]                   lane_ready_c;
    logic [RADIX-1:0]                   pop_c;
    logic                               merger_selected_c;
    logic                               out_last_c;
    logic [RADIX*COORD_BITS-1:0]        coord_in_c;

    // State and per-lane head registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            head_coord_q <= '0;
            head_vld_q   <= '0;
            head_last_q  <= '0;
            exhausted_q  <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_coord_q <= head_coord_d;
            head_vld_q   <= head_vld_d;
            head_last_q  <= head_last_d;
            exhausted_q  <= exhausted_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state, lane handshakes, pops and protocol checking
    always_comb begin
        logic [COORD_BITS-1:0] in_coord;
        logic                  all_present;
        logic                  all_exh;
        logic                  active;

        state_d           = state_q;
        head_coord_d      = head_coord_q;
        head_vld_d        = head_vld_q;
        head_last_d       = head_last_q;
        exhausted_d       = exhausted_q;
        error_d           = error_q;
        lane_ready_c      = '0;
        pop_c             = '0;
        merger_selected_c = 1'b0;
        out_last_c        = 1'b0;
        in_coord          = '0;

        all_present = &(head_vld_q | exhausted_q);
        all_exh     = &exhausted_q;
        active      = (state_q == S_FILL) || (state_q == S_MERGE);

        if (state_q == S_MERGE) begin
            merger_selected_c = bus.out_ready & all_present & ~all_exh;
        end

        if (merger_selected_c && ((bus.merger_fetch_next == '0) ||
            ((bus.merger_fetch_next & (bus.merger_fetch_next - RADIX'(1))) != '0))) begin
            error_d = 1'b1;
        end

        for (int unsigned i = 0; i < RADIX; i++) begin
            in_coord = bus.lane_coord[i*COORD_BITS +: COORD_BITS];
            pop_c[i] = merger_selected_c & bus.merger_fetch_next[i] & ~exhausted_q[i];
            lane_ready_c[i] = active & ~exhausted_q[i] & (~head_vld_q[i] | pop_c[i]);

            if (merger_selected_c && bus.merger_fetch_next[i] && exhausted_q[i]) begin
                error_d = 1'b1;
            end
            if ((state_q == S_MERGE) && bus.lane_valid[i] && exhausted_q[i] && (in_coord != SENTINEL)) begin
                error_d = 1'b1;
            end

            if (pop_c[i]) begin
                head_vld_d[i] = 1'b0;
                if (head_last_q[i]) begin
                    exhausted_d[i] = 1'b1;
                    if ((exhausted_q | (RADIX'(1) << i)) == ALL_LANES) begin
                        out_last_c = 1'b1;
                    end
                end
            end

            // Refill is accepted in the same cycle as a pop, so a lane sustains one element per cycle
            if (bus.lane_valid[i] && lane_ready_c[i]) begin
                if ((in_coord == SENTINEL) && bus.lane_last[i]) begin
                    exhausted_d[i] = 1'b1;
                end else begin
                    head_coord_d[i] = in_coord;
                    head_last_d[i]  = bus.lane_last[i];
                    head_vld_d[i]   = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FILL;
                    exhausted_d = '0;
                    head_vld_d  = '0;
                    error_d     = 1'b0;
                end
            end
            S_FILL: begin
                if (all_present) begin
                    state_d = all_exh ? S_DONE : S_MERGE;
                end
            end
            S_MERGE: begin
                if (merger_selected_c && out_last_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Empty or exhausted lanes present the sentinel so the merger never picks them
    always_comb begin
        coord_in_c = '0;
        for (int unsigned i = 0; i < RADIX; i++) begin
            coord_in_c[i*COORD_BITS +: COORD_BITS] = head_vld_q[i] ? head_coord_q[i] : SENTINEL;
        end
    end

    assign bus.lane_ready      = lane_ready_c;
    assign bus.merger_coord_in = coord_in_c;
    assign bus.merger_selected = merger_selected_c;
    assign bus.out_valid       = merger_selected_c;
    assign bus.out_coord       = merger_selected_c ? bus.merger_coord : '0;
    assign bus.out_last        = out_last_c;

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule
